fpadd_arbiter: RTL

Round-robin scheduler that shares one fpadd instance among NREQ requesters. It accepts one add request at a time over a per-requester valid/ready handshake. It sequences the adder's start/done protocol and routes the sum back to the granted requester. It sits between the requesting datapath blocks and the single fpadd unit.

---
 rtl/fpadd_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/fpadd_arbiter.sv
// Round-robin arbiter sharing one fpadd unit among NREQ requesters.
// Define FPADD_ARB_TIMEOUT_EN to add the WAIT-state timeout with error response.
module fpadd_arbiter #(
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 255
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [32*NREQ-1:0]   req_a,
   input  logic [32*NREQ-1:0]   req_b,
   output logic [NREQ-1:0]      req_ready,
   output logic [NREQ-1:0]      resp_valid,
   input  logic [NREQ-1:0]      resp_ready,
   output logic [31:0]          resp_sum,
   output logic                 resp_err,
   output logic                 add_start,
   output logic [31:0]          add_a,
   output logic [31:0]          add_b,
   input  logic [31:0]          add_sum,
   input  logic                 add_done
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [2:0] {IDLE, ISSUE, BLANK, WAIT, RESP} state_t;

   state_t          state;
   logic [IW-1:0]   ptr;
   logic [IW-1:0]   gnt;
   logic [IW-1:0]   sel;
   logic            found;
   logic [31:0]     sel_a;
   logic [31:0]     sel_b;

   // Search starts one past the last grant so the last-served requester ranks lowest.
   always_comb begin
      logic [IW-1:0] idx;
      found = 1'b0;
      sel   = '0;
      idx   = '0;
      sel_a = '0;
      sel_b = '0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = IW'((int'(ptr) + k) % NREQ);
         if (!found && req_valid[idx]) begin
            found = 1'b1;
            sel   = idx;
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         if (IW'(i) == sel) begin
            sel_a = req_a[32*i +: 32];
            sel_b = req_b[32*i +: 32];
         end
      end
   end

`ifdef FPADD_ARB_TIMEOUT_EN
   logic [15:0] to_cnt;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         ptr        <= IW'(NREQ-1);
         gnt        <= '0;
         req_ready  <= '0;
         resp_valid <= '0;
         resp_sum   <= '0;
         add_start  <= 1'b0;
         add_a      <= '0;
         add_b      <= '0;
`ifdef FPADD_ARB_TIMEOUT_EN
         resp_err   <= 1'b0;
         to_cnt     <= '0;
`endif
      end else begin
         req_ready <= '0;
         add_start <= 1'b0;
         case (state)
            IDLE: begin
               if (found) begin
                  req_ready <= NREQ'(1) << sel;
                  add_a     <= sel_a;
                  add_b     <= sel_b;
                  gnt       <= sel;
                  ptr       <= sel;
                  state     <= ISSUE;
               end
            end
            ISSUE: begin
               add_start <= 1'b1;
               state     <= BLANK;
            end
            // add_done may still be high from the previous op; it is not looked at here.
            BLANK: begin
`ifdef FPADD_ARB_TIMEOUT_EN
               to_cnt <= '0;
`endif
               state  <= WAIT;
            end
            WAIT: begin
               if (add_done) begin
                  resp_sum   <= add_sum;
                  resp_valid <= NREQ'(1) << gnt;
`ifdef FPADD_ARB_TIMEOUT_EN
                  resp_err   <= 1'b0;
`endif
                  state      <= RESP;
               end
`ifdef FPADD_ARB_TIMEOUT_EN
               else if (to_cnt == 16'(TIMEOUT - 1)) begin
                  resp_sum   <= 32'h7FC0_0000;
                  resp_err   <= 1'b1;
                  resp_valid <= NREQ'(1) << gnt;
                  state      <= RESP;
               end else begin
                  to_cnt <= to_cnt + 16'd1;
               end
`endif
            end
            RESP: begin
               if (resp_ready[gnt]) begin
                  resp_valid <= '0;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifndef FPADD_ARB_TIMEOUT_EN
   // TIMEOUT is at least 1, so this is a constant 0 with no counter behind it.
   assign resp_err = (TIMEOUT < 1);
`endif

endmodule
